// File: rtl/cordic_seq_ctrl_pkg.sv
// Shared definitions for the CORDIC sequencing controller, iteration core
// and arctan table: state encoding, mode constants and default sizes.
package cordic_seq_ctrl_pkg;

    localparam int CORDIC_M     = 32;
    localparam int CORDIC_N     = 5;
    localparam int CORDIC_ITERS = 16;

    localparam logic [1:0] MODE_ROT        = 2'b00;
    localparam logic [1:0] MODE_VEC        = 2'b01;
    localparam int         MODE_BYPASS_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_LOAD = 3'd2,
        ST_ITER = 3'd3,
        ST_CAPT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Bypass commands skip the micro-rotations entirely.
    function automatic logic is_bypass(input logic [1:0] mode);
        return mode[MODE_BYPASS_BIT];
    endfunction

endpackage

// File: rtl/cordic_rr_arb2.sv
// Two-way round-robin arbiter. Grants only while enabled; a grant is an
// accept (ready is driven straight from grant), so the pointer moves on
// every cycle that produces a grant.
module cordic_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1 means requester 1 was granted last; reset value lets requester 0
    // win the first tie.
    logic last_reg;

    // Single request wins outright; a tie goes to the one not granted last.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_reg ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer follows the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (grant != 2'b00) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequencing controller for the iterative CORDIC datapath: arbitrates two
// requesters, drives the pre-stage/core controls and returns the tagged result.
module cordic_seq_ctrl
    import cordic_seq_ctrl_pkg::*;
#(
    parameter int M     = CORDIC_M,
    parameter int N     = CORDIC_N,
    parameter int ITERS = CORDIC_ITERS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_mode,
    input  logic [M-1:0] req0_x,
    input  logic [M-1:0] req0_y,
    input  logic [M-1:0] req0_z,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_mode,
    input  logic [M-1:0] req1_x,
    input  logic [M-1:0] req1_y,
    input  logic [M-1:0] req1_z,
    output logic [1:0]   dp_mode,
    output logic [M-1:0] dp_x,
    output logic [M-1:0] dp_y,
    output logic [M-1:0] dp_z,
    output logic         dp_load,
    output logic         dp_iter_en,
    output logic [N-1:0] dp_iter_idx,
    input  logic [M-1:0] dp_x_res,
    input  logic [M-1:0] dp_y_res,
    input  logic [M-1:0] dp_z_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_x,
    output logic [M-1:0] out_y,
    output logic [M-1:0] out_z,
    output logic         out_src,
    output logic         busy
);

    localparam logic [N-1:0] LAST_IDX = N'(ITERS - 1);

    state_t       state_reg, state_next;
    logic [N-1:0] cnt_reg, cnt_next;
    logic [1:0]   grant;
    logic         accept;
    logic         arb_en;

    // Arbitration is only live in IDLE and is held off while reset is high
    // so that ready stays low during reset.
    assign arb_en = (state_reg == ST_IDLE) && !rst;

    cordic_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign out_valid  = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);

    // State and iteration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic plus the per-state datapath strobes.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dp_load     = 1'b0;
        dp_iter_en  = 1'b0;
        dp_iter_idx = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_PRE;
            end
            ST_PRE: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                dp_load = 1'b1;
                if (is_bypass(dp_mode)) begin
                    state_next = ST_CAPT;
                end else begin
                    state_next = ST_ITER;
                    cnt_next   = '0;
                end
            end
            ST_ITER: begin
                dp_iter_en  = 1'b1;
                dp_iter_idx = cnt_reg;
                if (cnt_reg == LAST_IDX) begin
                    state_next = ST_CAPT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CAPT: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command registers: loaded from the granted requester on accept and
    // held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_mode <= '0;
            dp_x    <= '0;
            dp_y    <= '0;
            dp_z    <= '0;
            out_src <= 1'b0;
        end else if (accept) begin
            dp_mode <= grant[1] ? req1_mode : req0_mode;
            dp_x    <= grant[1] ? req1_x    : req0_x;
            dp_y    <= grant[1] ? req1_y    : req0_y;
            dp_z    <= grant[1] ? req1_z    : req0_z;
            out_src <= grant[1];
        end
    end

    // Result capture from the core, held through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_x <= '0;
            out_y <= '0;
            out_z <= '0;
        end else if (state_reg == ST_CAPT) begin
            out_x <= dp_x_res;
            out_y <= dp_y_res;
            out_z <= dp_z_res;
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: a cycle-timeline reference model
// checks every cycle, a directed command table checks latency/pulse counts,
// plus arbitration, stall, async-reset and randomized phases.
`timescale 1ns/1ps
module tb_cordic_seq_ctrl;
    import cordic_seq_ctrl_pkg::*;

    localparam int M     = 32;
    localparam int N     = 5;
    localparam int ITERS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_mode, req1_mode;
    logic [M-1:0] req0_x, req0_y, req0_z, req1_x, req1_y, req1_z;
    logic [1:0]   dp_mode;
    logic [M-1:0] dp_x, dp_y, dp_z;
    logic         dp_load, dp_iter_en;
    logic [N-1:0] dp_iter_idx;
    logic [M-1:0] dp_x_res, dp_y_res, dp_z_res;
    logic         out_valid, out_ready;
    logic [M-1:0] out_x, out_y, out_z;
    logic         out_src, busy;

    always #5 clk = ~clk;

    cordic_seq_ctrl #(.M(M), .N(N), .ITERS(ITERS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
        .dp_mode(dp_mode), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
        .dp_load(dp_load), .dp_iter_en(dp_iter_en), .dp_iter_idx(dp_iter_idx),
        .dp_x_res(dp_x_res), .dp_y_res(dp_y_res), .dp_z_res(dp_z_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_src(out_src), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timeline since accept) ----------------
    bit           m_busy;
    int           m_t, m_lat;
    bit           m_last, m_src;
    logic [1:0]   m_mode;
    logic [M-1:0] m_x, m_y, m_z, m_ox, m_oy, m_oz;

    // measurements of the current command, taken from DUT outputs
    bit meas_active;
    int meas_t, meas_lat, meas_iter, meas_load;
    int acc_cnt = 0;
    bit acc_src_q[$];

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_lat = 0; m_last = 1; m_src = 0;
        m_mode = '0; m_x = '0; m_y = '0; m_z = '0;
        m_ox = '0; m_oy = '0; m_oz = '0;
        meas_active = 0;
    endtask

    task automatic check_cycle();
        int g;
        bit ex_load, ex_iter, ex_ov;
        int ex_idx;
        if (rst) begin
            model_reset();
            chk("rst_busy", busy, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_ready", {req0_ready, req1_ready}, 0);
            chk("rst_strobes", {dp_load, dp_iter_en, dp_iter_idx}, 0);
            chk("rst_dp", |{dp_mode, dp_x, dp_y, dp_z}, 0);
            chk("rst_out", |{out_x, out_y, out_z, out_src}, 0);
            return;
        end
        ex_load = m_busy && m_t == 2;
        ex_iter = m_busy && !m_mode[1] && m_t >= 3 && m_t <= ITERS + 2;
        ex_idx  = ex_iter ? m_t - 3 : 0;
        ex_ov   = m_busy && m_t >= m_lat;
        g = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) g = m_last ? 0 : 1;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        chk("busy", busy, m_busy);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("dp_load", dp_load, ex_load);
        chk("dp_iter_en", dp_iter_en, ex_iter);
        chk("dp_iter_idx", dp_iter_idx, ex_idx);
        chk("out_valid", out_valid, ex_ov);
        chk("dp_mode", dp_mode, m_mode);
        chk("dp_x", dp_x, m_x);
        chk("dp_y", dp_y, m_y);
        chk("dp_z", dp_z, m_z);
        chk("out_src", out_src, m_src);
        chk("out_x", out_x, m_ox);
        chk("out_y", out_y, m_oy);
        chk("out_z", out_z, m_oz);

        if (meas_active) begin
            meas_t++;
            if (dp_load)    meas_load++;
            if (dp_iter_en) meas_iter++;
            if (out_valid && meas_lat < 0) meas_lat = meas_t;
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            meas_active = 1; meas_t = 0; meas_load = 0; meas_iter = 0; meas_lat = -1;
            acc_cnt++;
            acc_src_q.push_back(req1_ready);
        end

        if (g >= 0) begin
            m_busy = 1; m_t = 1; m_src = (g == 1); m_last = (g == 1);
            m_mode = (g == 1) ? req1_mode : req0_mode;
            m_x    = (g == 1) ? req1_x : req0_x;
            m_y    = (g == 1) ? req1_y : req0_y;
            m_z    = (g == 1) ? req1_z : req0_z;
            m_lat  = m_mode[1] ? 4 : ITERS + 4;
        end else if (m_busy) begin
            if (m_t == m_lat - 1) begin
                m_ox = dp_x_res; m_oy = dp_y_res; m_oz = dp_z_res;
            end
            if (m_t >= m_lat && out_ready) m_busy = 0;
            else m_t++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        check_cycle();
    end

    // core result bus changes every cycle so capture timing is observable
    initial forever begin
        @(posedge clk); #1;
        dp_x_res = $urandom; dp_y_res = $urandom; dp_z_res = $urandom;
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        bit           src;
        logic [1:0]   mode;
        logic [M-1:0] x, y, z;
        int           exp_lat;
        int           exp_iters;
        int           ready_low;
    } vec_t;

    vec_t vecs[4];

    task automatic drive_req(input bit src, input bit v, input logic [1:0] mode,
                             input logic [M-1:0] x, input logic [M-1:0] y, input logic [M-1:0] z);
        if (src) begin
            req1_valid = v; req1_mode = mode; req1_x = x; req1_y = y; req1_z = z;
        end else begin
            req0_valid = v; req0_mode = mode; req0_x = x; req0_y = y; req0_z = z;
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk); #1;
            if (!busy) idle = 1;
        end
        chk(name, idle, 1);
    endtask

    task automatic wait_accept(input bit src, input string name);
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #1;
            if (src ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) got = 1;
        end
        chk(name, got, 1);
    endtask

    task automatic run_entry(input vec_t v);
        bit           seen = 0;
        logic [M-1:0] hold_x;
        @(posedge clk); #1;
        drive_req(v.src, 1'b1, v.mode, v.x, v.y, v.z);
        wait_accept(v.src, "vec_accept");
        @(posedge clk); #1;
        drive_req(v.src, 1'b0, v.mode, v.x, v.y, v.z);
        if (v.ready_low > 0) out_ready = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("vec_done_seen", seen, 1);
        chk("vec_latency", meas_lat, v.exp_lat);
        chk("vec_iter_pulses", meas_iter, v.exp_iters);
        chk("vec_load_pulses", meas_load, 1);
        chk("vec_out_src", out_src, v.src);
        chk("vec_dp_x", dp_x, v.x);
        chk("vec_dp_mode", dp_mode, v.mode);
        $display("vec src=%0d mode=%0b x=%08h latency=%0d iters=%0d", v.src, v.mode, v.x, meas_lat, meas_iter);
        if (v.ready_low > 0) begin
            hold_x = out_x;
            @(posedge clk); #1;
            drive_req(1'b0, 1'b1, 2'b10, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333);
            for (int k = 0; k < v.ready_low; k++) begin
                @(negedge clk); #1;
                chk("stall_out_valid", out_valid, 1);
                chk("stall_out_x", out_x, hold_x);
                chk("stall_req0_ready", req0_ready, 0);
            end
            @(posedge clk); #1;
            out_ready = 1;
            @(negedge clk); #1;
            chk("hs_out_valid", out_valid, 1);
            @(negedge clk); #1;
            chk("accept_after_hs", req0_ready, 1);
            @(posedge clk); #1;
            req0_valid = 0;
        end
        wait_idle("vec_idle");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        bit found;
        req0_valid = 0; req1_valid = 0; req0_mode = '0; req1_mode = '0;
        req0_x = '0; req0_y = '0; req0_z = '0; req1_x = '0; req1_y = '0; req1_z = '0;
        out_ready = 1; dp_x_res = '0; dp_y_res = '0; dp_z_res = '0;

        vecs[0] = '{1'b0, MODE_ROT, 32'h26DD3B6A, 32'h00000000, 32'h1921FB54, 20, 16, 0};
        vecs[1] = '{1'b1, 2'b10,    32'h12345678, 32'hFEDCBA98, 32'h0BADF00D, 4, 0, 0};
        vecs[2] = '{1'b1, MODE_VEC, 32'hC0000000, 32'h40000000, 32'h00000000, 20, 16, 0};
        vecs[3] = '{1'b0, 2'b11,    32'h80000001, 32'h7FFFFFFF, 32'hDEADBEEF, 4, 0, 5};

        repeat (3) @(posedge clk);
        #1 rst = 0;

        // both requesters valid for four commands: expect 0,1,0,1
        base = acc_cnt;
        acc_src_q.delete();
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, MODE_ROT, 32'h11111111, 32'h22222222, 32'h33333333);
        drive_req(1'b1, 1'b1, MODE_VEC, 32'h44444444, 32'h55555555, 32'h66666666);
        for (int i = 0; i < 400 && acc_cnt < base + 4; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("arb_count", acc_cnt - base, 4);
        for (int k = 0; k < 4 && k < acc_src_q.size(); k++) begin
            chk("arb_order", acc_src_q[k], k % 2);
            $display("arb grant %0d -> requester %0d", k, acc_src_q[k]);
        end
        wait_idle("arb_idle");

        // directed command table
        for (int i = 0; i < 4; i++) run_entry(vecs[i]);

        // async reset in the middle of ITER
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, MODE_ROT, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C);
        wait_accept(1'b0, "rst_test_accept");
        @(posedge clk); #1;
        req0_valid = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); #1;
            if (dp_iter_en && dp_iter_idx == 5'd7) found = 1;
        end
        chk("reach_idx7", found, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_idx", dp_iter_idx, 0);
        chk("async_rst_outputs", |{dp_load, dp_iter_en, dp_mode, dp_x, dp_y, dp_z,
                                  out_x, out_y, out_z, out_src, req0_ready, req1_ready}, 0);
        $display("async reset mid-ITER: busy=%0d out_valid=%0d idx=%0d", busy, out_valid, dp_iter_idx);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        drive_req(1'b0, 1'b1, 2'b10, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0F0F0F0F);
        @(negedge clk); #1;
        chk("post_rst_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        wait_idle("post_rst_idle");

        // randomized traffic against the model
        base = acc_cnt;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            drive_req(1'b0, $urandom_range(0, 1) == 1, 2'($urandom), $urandom, $urandom, $urandom);
            drive_req(1'b1, $urandom_range(0, 1) == 1, 2'($urandom), $urandom, $urandom, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; out_ready = 1;
        wait_idle("random_idle");
        $display("random phase: %0d commands accepted", acc_cnt - base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time limit
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_seq_ctrl.md
Name: cordic_seq_ctrl

Overview:
- Sequencing controller for the iterative CORDIC datapath: pre-stage quadrant correction followed by the iteration core.
- Arbitrates between two requesters using round-robin and valid/ready handshakes.
- Drives the command registers into the pre-stage, then the core load, iteration enable and iteration index.
- Captures the core result and presents it on a valid/ready output port tagged with the source requester.

Parameters:
M, 32, data width of x/y/z (signed, fixed-point as used by the pre-stage)
N, 5, width of iteration index
ITERS, 16, number of micro-rotations per command; legal range 1..2^N

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle when valid
req0_mode  in  2  requester 0 mode (00 rotation, 01 vectoring, 1x bypass)
req0_x, req0_y, req0_z  in  M each  requester 0 operands, signed
req1_valid, req1_ready, req1_mode, req1_x, req1_y, req1_z  same as requester 0, for requester 1
dp_mode  out  2  registered mode to pre-stage
dp_x, dp_y, dp_z  out  M each  registered operands to pre-stage
dp_load  out  1  core loads pre-stage outputs x_0/y_0/z_0
dp_iter_en  out  1  core performs one micro-rotation
dp_iter_idx  out  N  shift/arctan-table index for the current micro-rotation
dp_x_res, dp_y_res, dp_z_res  in  M each  core result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_x, out_y, out_z  out  M each  captured result
out_src  out  1  requester that issued the result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including dp_*, out_*, busy and dp_iter_idx; RR pointer set so requester 0 wins the first tie; iteration counter 0. Reset mid-operation aborts the command with no output.
- Arbitration, combinational in IDLE only:
  - Only one valid: grant that requester.
  - Both valid: grant the requester not granted last.
  - reqK_ready = (state==IDLE) & grant==K; reqK_ready is 0 outside IDLE.
  - Pointer updates on the accept cycle only.
- Accept cycle (valid&ready): register mode/x/y/z into dp_*, record out_src, go to PRE. dp_* stay stable until the next accept.
- PRE, 1 cycle: the pre-stage samples dp_*. Go to LOAD.
- LOAD, 1 cycle: dp_load=1.
  - mode[1]==0: go to ITER, counter=0.
  - mode[1]==1: go to CAPT (bypass, no iterations).
- ITER, ITERS cycles: dp_iter_en=1, dp_iter_idx=counter, counter increments. At counter==ITERS-1 go to CAPT and clear the counter. dp_iter_idx returns to 0 outside ITER.
- CAPT, 1 cycle: out_x/y/z <= dp_*_res. Go to DONE.
- DONE: out_valid=1 with out_* held stable. On out_ready go to IDLE; out_valid drops the next cycle. A new grant is possible the cycle after the handshake (no combinational ready-through).
- dp_load and dp_iter_en are never high together; exactly one dp_load pulse per command.
- Latency, accept edge to out_valid:
  - Non-bypass: ITERS+4 cycles (20 at default).
  - Bypass: 4 cycles.
- Throughput: one command in flight. The next accept is no earlier than 1 cycle after the output handshake.
- Data is not interpreted; no width growth. The controller passes signed values unmodified.
- Mode 01 with negative x is forwarded unchanged; pre-stage sign handling is the datapath's job.

Decomposition:
- Shared package: state encoding (IDLE, PRE, LOAD, ITER, CAPT, DONE), mode constants (MODE_ROT=2'b00, MODE_VEC=2'b01, bypass bit index 1), and ITERS/N defaults shared with the iteration core and arctan table.
- One sub-module: cordic_rr_arb2 (2-way round-robin grant with pointer register, async reset).
- FSM, counter and capture registers stay in the top module.

Test Plan:
- Reset during ITER (counter=7): assert rst asynchronously mid-cycle -> all outputs 0 immediately, busy=0, no out_valid; after release, req0 is accepted on the first valid.
- req0 mode 00, x=0x26DD3B6A, y=0, z=0x1921FB54, out_ready=1 -> dp_* equal inputs from the cycle after accept; one dp_load; dp_iter_idx 0..15 on 16 consecutive cycles; out_valid exactly 20 cycles after accept; out_src=0; out_* equal the dp_*_res sampled in CAPT.
- req0 and req1 both valid continuously for 4 commands -> grant order 0,1,0,1; each reqK_ready is a single-cycle pulse only in IDLE.
- req1 mode 10 -> no dp_iter_en pulses; out_valid 4 cycles after accept; out_src=1.
- out_ready held low 5 cycles in DONE while req0_valid=1 -> out_valid and out_* stable, req0_ready=0; after the handshake, req0 is accepted in the following cycle.
- req1 mode 01, x=0xC0000000 -> dp_x=0xC0000000, dp_mode=01, normal 20-cycle latency.
